// File: rtl/step_pulse_monitor.sv
// step_pulse_monitor: recovers position, step count, pulse interval and motion phase
// from an asynchronous step/dir pulse train, and flags end of motion after a quiet time.
module step_pulse_monitor #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        step,
    input  logic        dir,
    output logic [31:0] position,
    output logic [31:0] step_count,
    output logic [31:0] last_period,
    output logic [31:0] min_period,
    output logic        period_valid,
    output logic [1:0]  phase,
    output logic        moving,
    output logic        motion_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEL = 2'd1, CRUISE = 2'd2, DECEL = 2'd3} phase_t;

    logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d, dir_sync_q, dir_sync_d, fill_q, fill_d;
    logic                   step_dly_q, step_dly_d, armed_q, armed_d;
    logic                   step_s, dir_s, rise, expire;
    logic [31:0]            position_q, position_d, count_q, count_d;
    logic [31:0]            last_q, last_d, min_q, min_d, ivl_q, ivl_d;
    logic                   period_valid_q, period_valid_d, moving_q, moving_d;
    logic                   done_q, done_d, have_prev_q, have_prev_d;
    phase_t                 phase_q, phase_d;

    assign step_s = step_sync_q[SYNC_STAGES-1];
    assign dir_s  = dir_sync_q[SYNC_STAGES-1];
    // fill_q marks which synchronizer stages hold real samples since reset, so a step
    // held high across reset release is only accepted after a genuine low is seen
    assign rise   = step_s & ~step_dly_q & armed_q;
    assign expire = moving_q && (ivl_q >= TIMEOUT);

    always_comb begin
        step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step};
        dir_sync_d  = {dir_sync_q[SYNC_STAGES-2:0], dir};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        step_dly_d  = step_s;
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ~step_s);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            fill_q      <= '0;
            step_dly_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            step_sync_q <= step_sync_d;
            dir_sync_q  <= dir_sync_d;
            fill_q      <= fill_d;
            step_dly_q  <= step_dly_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        position_d     = position_q;
        count_d        = count_q;
        last_d         = last_q;
        min_d          = min_q;
        ivl_d          = (ivl_q == '1) ? ivl_q : ivl_q + 32'd1;
        period_valid_d = 1'b0;
        moving_d       = moving_q;
        done_d         = 1'b0;
        have_prev_d    = have_prev_q;
        phase_d        = phase_q;
        if (!enable) begin
            position_d  = '0;
            count_d     = '0;
            last_d      = '0;
            min_d       = '1;
            ivl_d       = '0;
            moving_d    = 1'b0;
            have_prev_d = 1'b0;
            phase_d     = IDLE;
        end else if (rise) begin
            position_d = position_q + (dir_s ? 32'd1 : 32'hFFFF_FFFF);
            count_d    = count_q + 32'd1;
            ivl_d      = 32'd1;
            moving_d   = 1'b1;
            // the first rise of a motion only starts timing; periods begin with the second
            have_prev_d = moving_q;
            if (moving_q) begin
                last_d         = ivl_q;
                min_d          = (ivl_q < min_q) ? ivl_q : min_q;
                period_valid_d = 1'b1;
                phase_d        = (!have_prev_q || ivl_q < last_q) ? ACCEL :
                                 (ivl_q == last_q) ? CRUISE : DECEL;
            end
        end else if (expire) begin
            moving_d = 1'b0;
            phase_d  = IDLE;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position_q     <= '0;
            count_q        <= '0;
            last_q         <= '0;
            min_q          <= '1;
            ivl_q          <= '0;
            period_valid_q <= 1'b0;
            moving_q       <= 1'b0;
            done_q         <= 1'b0;
            have_prev_q    <= 1'b0;
            phase_q        <= IDLE;
        end else begin
            position_q     <= position_d;
            count_q        <= count_d;
            last_q         <= last_d;
            min_q          <= min_d;
            ivl_q          <= ivl_d;
            period_valid_q <= period_valid_d;
            moving_q       <= moving_d;
            done_q         <= done_d;
            have_prev_q    <= have_prev_d;
            phase_q        <= phase_d;
        end
    end

    assign position     = position_q;
    assign step_count   = count_q;
    assign last_period  = last_q;
    assign min_period   = min_q;
    assign period_valid = period_valid_q;
    assign phase        = phase_q;
    assign moving       = moving_q;
    assign motion_done  = done_q;
endmodule

// File: doc/step_pulse_monitor.md
Name: step_pulse_monitor

Overview:
- Receive-side counterpart of the trapezoidal step generator: observes a step/dir pulse train, as driven to a stepper driver or looped back from it.
- Recovers signed position, step count, the interval between pulses, and the motion phase (accelerating/cruising/decelerating).
- Reports end of motion after a configurable quiet time.
- Used for closed-loop checking of executed moves against commanded N, and for status readback to the host.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer for step and dir (minimum 2).
- TIMEOUT, 32'd1000000, idle clk cycles after the last detected step edge before motion is declared finished.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  arm the monitor; low clears all counters and status synchronously
- step  input  1  step pulse, asynchronous to clk; a step is a rising edge
- dir  input  1  direction, asynchronous; 1 = +1 per step, 0 = -1 per step
- position  output  32  signed step position since arm (two's complement, wraps)
- step_count  output  32  unsigned count of detected steps since arm (wraps)
- last_period  output  32  clk cycles between the last two detected step edges
- min_period  output  32  smallest last_period since arm (shortest interval, i.e. peak speed)
- period_valid  output  1  one-cycle pulse when last_period is updated
- phase  output  2  0 IDLE, 1 ACCEL, 2 CRUISE, 3 DECEL
- moving  output  1  high from first detected edge until timeout
- motion_done  output  1  one-cycle pulse on timeout expiry

Behaviour:
- Reset (async) and enable=0 (sync): all outputs 0, except min_period = 32'hFFFFFFFF. The synchronizer chain is cleared on reset only.
- Synchronization:
  - step and dir each pass through SYNC_STAGES flops.
  - A rise is detected when the synchronized step is 1 and its one-cycle-delayed copy is 0.
  - Output latency from the first clk edge sampling step high to the updated step_count/position is SYNC_STAGES+1 clk edges.
- Position: on each rise, step_count += 1, and position += 1 if synchronized dir = 1, else -= 1. Dir is sampled in the same cycle as the rise.
- Interval counter:
  - 32-bit counter, cleared to 1 on each rise, increments every cycle, saturates at 32'hFFFFFFFF (no wrap).
  - A constant pulse train with rises every P clk cycles yields last_period = P.
- Rise handling:
  - First rise after arm: sets moving = 1 and starts the interval counter. last_period, period_valid and phase are unchanged (phase stays IDLE).
  - Each subsequent rise: last_period <= counter value; period_valid = 1 for one cycle; min_period <= min(min_period, new period).
- Phase, evaluated on each period update against the previous last_period:
  - First period after arm: ACCEL.
  - New < previous: ACCEL.
  - New == previous: CRUISE.
  - New > previous: DECEL.
- Timeout:
  - While moving = 1, if the interval counter reaches TIMEOUT with no new rise: moving <= 0, phase <= IDLE, motion_done = 1 for one cycle.
  - step_count, position, last_period and min_period are held.
  - A rise on the same cycle as expiry takes priority; no motion_done is generated.
  - After a timeout, the next rise is treated as a first rise: no period update, and phase is re-evaluated from the following period as ACCEL.
- Glitches: pulses shorter than one clk period may be missed; there is no requirement to catch them. A high time ≥ 2 clk and a low time ≥ 2 clk is guaranteed to be detected.
- enable falling mid-motion: clears everything on the next clk edge; no motion_done is generated.
- Reset mid-motion: immediate clear, including the synchronizer. A step held high across reset release is not counted until it goes low and rises again.

Test Plan:
- Arm; apply 10 pulses every 100 clk, high 50, dir=1 -> step_count=10, position=10, last_period=100, min_period=100, phase CRUISE from the 3rd pulse on, 9 period_valid pulses; TIMEOUT cycles after the last rise -> exactly one motion_done, moving=0, phase=IDLE, counts held.
- Intervals 400, 300, 200, 200, 300, 400 -> phase sequence ACCEL, ACCEL, ACCEL, CRUISE, DECEL, DECEL; min_period=200; last_period=400.
- 5 pulses dir=1, then 8 pulses dir=0 -> position=-3 (32'hFFFFFFFD), step_count=13.
- Use TIMEOUT=50 with a pulse period of 60 -> motion_done after each rise; step_count still increments; period_valid never asserts.
- Assert reset for 1 cycle mid-train, with step high at release -> all outputs 0, min_period=all-ones; that pulse is not counted; the next rise counts as step 1.
- Drop enable for 3 cycles mid-train, then re-arm -> counters 0 and no motion_done; the first rise after re-arm gives step_count=1 and no period_valid.
